// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode hex 7-segment scan driver with double-buffered data,
// guard blanking between digits and per-digit blank/dp masks. Optional macro: LEADING_ZERO_SUPPRESS_EN.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    function automatic logic [6:0] glyph(input logic [3:0] hex);
        logic [6:0] g;
        case (hex)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            4'hF:    g = 7'b1000111;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    state_t                  state_r, state_s;
    logic [GW-1:0]           guard_cnt_r, guard_cnt_s;
    logic [PW-1:0]           pre_cnt_r, pre_cnt_s;
    logic [IW-1:0]           digit_idx_r, digit_idx_s;
    logic                    wrap_s;

    logic [4*NUM_DIGITS-1:0] pend_value_r, shd_value_r;
    logic [NUM_DIGITS-1:0]   pend_blank_r, shd_blank_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r, shd_dp_r;
    logic                    pend_valid_r;

    logic [6:0]              seg_r, seg_s;
    logic                    dp_r, dp_s;
    logic [NUM_DIGITS-1:0]   an_r, an_s;
    logic                    frame_done_r;
    logic                    suppress_s;

    // Next-state logic for the BLANK/SHOW scan sequencer and its counters.
    always_comb begin
        state_s     = state_r;
        guard_cnt_s = guard_cnt_r;
        pre_cnt_s   = pre_cnt_r;
        digit_idx_s = digit_idx_r;
        wrap_s      = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (guard_cnt_r == GW'(GUARD_CYCLES - 1)) begin
                    state_s     = ST_SHOW;
                    guard_cnt_s = {GW{1'b0}};
                    pre_cnt_s   = {PW{1'b0}};
                end else begin
                    guard_cnt_s = guard_cnt_r + GW'(1);
                end
            end
            ST_SHOW: begin
                if (pre_cnt_r == PW'(PRESCALE - 1)) begin
                    state_s     = ST_BLANK;
                    pre_cnt_s   = {PW{1'b0}};
                    guard_cnt_s = {GW{1'b0}};
                    if (digit_idx_r == IW'(NUM_DIGITS - 1)) begin
                        digit_idx_s = {IW{1'b0}};
                        wrap_s      = 1'b1;
                    end else begin
                        digit_idx_s = digit_idx_r + IW'(1);
                    end
                end else begin
                    pre_cnt_s = pre_cnt_r + PW'(1);
                end
            end
            default: begin
                state_s     = ST_BLANK;
                guard_cnt_s = {GW{1'b0}};
                pre_cnt_s   = {PW{1'b0}};
                digit_idx_s = {IW{1'b0}};
            end
        endcase
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    // Digit k>=1 goes dark when it and every more-significant digit are zero.
    always_comb begin
        logic [NUM_DIGITS-1:0] lz_mask;
        logic                  all_zero;
        lz_mask  = {NUM_DIGITS{1'b0}};
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero & (shd_value_r[4*k +: 4] == 4'h0);
            lz_mask[k] = all_zero;
        end
        suppress_s = lz_mask[digit_idx_r];
    end
`else
    assign suppress_s = 1'b0;
`endif

    // Output pattern for the state being entered; shadow data only changes entering BLANK.
    always_comb begin
        seg_s = SEG_OFF;
        dp_s  = DP_OFF;
        an_s  = AN_OFF;
        if (state_s == ST_SHOW) begin
            seg_s = suppress_s ? SEG_OFF : (glyph(shd_value_r[4*int'(digit_idx_r) +: 4]) ^ SEG_OFF);
            dp_s  = shd_dp_r[digit_idx_r] ? ~DP_OFF : DP_OFF;
            an_s  = shd_blank_r[digit_idx_r] ? AN_OFF
                                             : ((NUM_DIGITS'(1'b1) << digit_idx_r) ^ AN_OFF);
        end else begin
            seg_s = SEG_OFF;
            dp_s  = DP_OFF;
            an_s  = AN_OFF;
        end
    end

    // Sequencer state, counters and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BLANK;
            guard_cnt_r  <= {GW{1'b0}};
            pre_cnt_r    <= {PW{1'b0}};
            digit_idx_r  <= {IW{1'b0}};
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            guard_cnt_r  <= guard_cnt_s;
            pre_cnt_r    <= pre_cnt_s;
            digit_idx_r  <= digit_idx_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            an_r         <= an_s;
            frame_done_r <= wrap_s;
        end
    end

    // Pending/shadow double buffer; a load landing on the wrap edge bypasses to shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_r <= {(4*NUM_DIGITS){1'b0}};
            pend_blank_r <= {NUM_DIGITS{1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_valid_r <= 1'b0;
            shd_value_r  <= {(4*NUM_DIGITS){1'b0}};
            shd_blank_r  <= {NUM_DIGITS{1'b0}};
            shd_dp_r     <= {NUM_DIGITS{1'b0}};
        end else if (wrap_s) begin
            pend_valid_r <= 1'b0;
            if (load) begin
                shd_value_r <= value;
                shd_blank_r <= blank_mask;
                shd_dp_r    <= dp_mask;
            end else if (pend_valid_r) begin
                shd_value_r <= pend_value_r;
                shd_blank_r <= pend_blank_r;
                shd_dp_r    <= pend_dp_r;
            end else begin
                shd_value_r <= shd_value_r;
            end
        end else if (load) begin
            pend_value_r <= value;
            pend_blank_r <= blank_mask;
            pend_dp_r    <= dp_mask;
            pend_valid_r <= 1'b1;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, PRESCALE=4, GUARD=1, active-low pins).
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int G     = 1;
    localparam int SLOT  = G + P;
    localparam int FRAME = N * SLOT;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int vectors;
    int miscompares;
    int n;
    logic [15:0] sh_v, lt_v;
    logic [3:0]  sh_b, sh_d, lt_b, lt_d;

    seven_seg_scan_driver #(
        .NUM_DIGITS(N), .PRESCALE(P), .GUARD_CYCLES(G),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .blank_mask(blank_mask), .dp_mask(dp_mask),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] font(input logic [3:0] h);
        logic [6:0] tab [16];
        tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return tab[h];
    endfunction

    task automatic compare(input string tag, input logic [6:0] es, input logic ed,
                           input logic [3:0] ean, input logic efd);
        vectors++;
        assert (seg === es) else begin
            miscompares++;
            $error("FAIL %s seg n=%0d observed %b expected %b", tag, n, seg, es);
        end
        vectors++;
        assert (dp === ed) else begin
            miscompares++;
            $error("FAIL %s dp n=%0d observed %b expected %b", tag, n, dp, ed);
        end
        vectors++;
        assert (an === ean) else begin
            miscompares++;
            $error("FAIL %s an n=%0d observed %b expected %b", tag, n, an, ean);
        end
        vectors++;
        assert (frame_done === efd) else begin
            miscompares++;
            $error("FAIL %s frame_done n=%0d observed %b expected %b", tag, n, frame_done, efd);
        end
    endtask

    // Expected pins derived from the clock count since reset release and the frame's data.
    task automatic check_model(input string tag);
        int d;
        logic [6:0] es;
        logic ed;
        logic [3:0] ean;
        d   = (n / SLOT) % N;
        es  = 7'h7F;
        ed  = 1'b1;
        ean = 4'hF;
        if ((n % SLOT) >= G) begin
            es = ~font(sh_v[4*d +: 4]);
`ifdef LEADING_ZERO_SUPPRESS_EN
            if (d >= 1 && (sh_v >> (4*d)) == 16'h0) es = 7'h7F;
`endif
            ed  = ~sh_d[d];
            ean = sh_b[d] ? 4'hF : ~(4'b0001 << d);
        end
        compare(tag, es, ed, ean, (n > 0) && (n % FRAME == 0));
    endtask

    task automatic tick(input string tag, input logic ld, input logic [15:0] v,
                        input logic [3:0] bm, input logic [3:0] dm);
        load = ld; value = v; blank_mask = bm; dp_mask = dm;
        @(posedge clk);
        n++;
        if (ld) begin
            lt_v = v; lt_b = bm; lt_d = dm;
        end
        if (n % FRAME == 0) begin
            sh_v = lt_v; sh_b = lt_b; sh_d = lt_d;
        end
        #1;
        check_model(tag);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int k);
        for (int i = 0; i < k; i++) tick(tag, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic run_to(input string tag, input int pos);
        while (n % FRAME != pos) tick(tag, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic model_reset();
        n = 0;
        sh_v = 16'h0; sh_b = 4'h0; sh_d = 4'h0;
        lt_v = 16'h0; lt_b = 4'h0; lt_d = 4'h0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        rst_n = 1'b1; load = 1'b0; value = 16'h0; blank_mask = 4'h0; dp_mask = 4'h0;
        #2 rst_n = 1'b0;
        #1 compare("reset", 7'h7F, 1'b1, 4'hF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        compare("reset_hold", 7'h7F, 1'b1, 4'hF, 1'b0);
        rst_n = 1'b1;

        // Idle scan of the all-zero shadow: first SHOW is digit 0 after one guard clock.
        idle("idle", 2 * FRAME);

        // Single load, shown from the frame after it.
        run_to("a18f_wait", 7);
        tick("a18f_load", 1'b1, 16'hA18F, 4'h0, 4'h0);
        idle("a18f", 2 * FRAME);

        // Two loads in one frame: last wins and nothing changes mid-frame.
        run_to("lastwins_wait", 2);
        for (int i = 0; i < FRAME; i++) begin
            if (i == 0)      tick("lastwins", 1'b1, 16'h1234, 4'h0, 4'h0);
            else if (i == 7) tick("lastwins", 1'b1, 16'h5678, 4'h0, 4'h0);
            else             tick("lastwins", 1'b0, 16'h0, 4'h0, 4'h0);
        end
        idle("lastwins", FRAME);

        // Blank and decimal-point masks.
        tick("masks_load", 1'b1, 16'h9C3E, 4'b0100, 4'b0001);
        idle("masks", 2 * FRAME);

        // Load coincident with the frame boundary goes straight to display.
        run_to("coinc_wait", FRAME - 1);
        tick("coinc_load", 1'b1, 16'hBEEF, 4'b1000, 4'b0110);
        idle("coinc", FRAME);

        // Leading-zero style values (suppression only when the macro is defined).
        tick("lz_load", 1'b1, 16'h0070, 4'h0, 4'h0);
        idle("lz70", 2 * FRAME);
        tick("lz_load0", 1'b1, 16'h0000, 4'h0, 4'b0100);
        idle("lz0", 2 * FRAME);

        // Randomized loads at random points of the scan.
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(7) == 0)
                tick("rand", 1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                tick("rand", 1'b0, 16'h0, 4'h0, 4'h0);
        end
        run_to("rand_flush", 0);
        idle("rand_flush", FRAME);

        // Asynchronous reset during digit 2 SHOW, then restart from digit 0 with zero shadow.
        tick("rst_load", 1'b1, 16'h4D2B, 4'h0, 4'h0);
        run_to("rst_wait", 0);
        run_to("rst_wait", 2 * SLOT + 2);
        #2 rst_n = 1'b0;
        #1 compare("async_reset", 7'h7F, 1'b1, 4'hF, 1'b0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle("after_reset", 2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-anode hex 7-segment display.
- Double-buffers a packed hex value and scans one digit at a time, with a guard (ghost-blanking) interval between digits.
- Per-digit blanking and decimal-point masks.
- Sits between datapath status registers and the board display pins; replaces per-digit static hex decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, clocks each digit is lit (SHOW length); ≥1.
- GUARD_CYCLES, 2, clocks all anodes are off before each digit (BLANK length); ≥1.
- SEG_ACTIVE_LOW, 1, 1: segment/dp pins are active-low; 0: active-high.
- AN_ACTIVE_LOW, 1, 1: anode enables are active-low; 0: active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- value  in  4*NUM_DIGITS  packed hex digits; digit k = value[4k+3:4k]; digit 0 is rightmost, on an[0].
- load  in  1  one-cycle strobe; captures value, blank_mask and dp_mask into the pending buffer.
- blank_mask  in  NUM_DIGITS  1 = digit forced dark (anode stays off in its slot).
- dp_mask  in  NUM_DIGITS  1 = decimal point lit for that digit.
- seg  out  7  {a,b,c,d,e,f,g}, a = MSB.
- dp  out  1  decimal point.
- an  out  NUM_DIGITS  one-hot digit enable (polarity per AN_ACTIVE_LOW).
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (rst_n); all state and outputs are registered.
- Reset values:
  - State BLANK, digit_idx = 0, counters = 0.
  - Pending and shadow buffers = 0, pending_valid = 0.
  - Outputs inactive: seg and dp off (7'h7F and 1 when active-low), an all off, frame_done = 0.
- Glyph table, active-high a..g; inverted when SEG_ACTIVE_LOW=1:

  | Digit | a..g | Digit | a..g |
  |---|---|---|---|
  | 0 | 1111110 | 8 | 1111111 |
  | 1 | 0110000 | 9 | 1111011 |
  | 2 | 1101101 | A | 1110111 |
  | 3 | 1111001 | b | 0011111 |
  | 4 | 0110011 | C | 1001110 |
  | 5 | 1011011 | d | 0111101 |
  | 6 | 1011111 | E | 1001111 |
  | 7 | 1110000 | F | 1000111 |

- FSM, two states:
  - BLANK: an all off, seg/dp off; guard_cnt counts 0..GUARD_CYCLES-1, then → SHOW with pre_cnt = 0.
  - SHOW: an one-hot at digit_idx, unless blank_shadow[digit_idx] = 1 (then an stays off). seg = glyph(shadow digit), dp per dp_shadow. pre_cnt counts 0..PRESCALE-1, then → BLANK with digit_idx + 1.
- Timing: the digit slot is exactly GUARD_CYCLES + PRESCALE clocks. Frame = NUM_DIGITS × slot. Outputs change on the clock edge entering each state.
- Wrap: leaving SHOW with digit_idx = NUM_DIGITS-1 sets digit_idx to 0 and pulses frame_done for that one cycle.
- Buffering:
  - load writes the pending buffer and sets pending_valid.
  - At the frame boundary (the frame_done cycle), pending_valid = 1 copies pending → shadow and clears pending_valid.
  - The displayed data never changes mid-frame.
  - Multiple loads in one frame: last wins.
  - load coincident with the frame boundary: the incoming value goes directly to shadow and pending_valid stays 0.
- Reset asserted mid-frame: immediate return to reset values. The first SHOW after release is digit 0, after GUARD_CYCLES clocks.
- Unused input values, including blank_mask bits above digit range, cannot occur because widths are exact.

Optional Feature:
- Macro LEADING_ZERO_SUPPRESS_EN.
- Defined: digit k (k ≥ 1) is additionally blanked when shadow digits k..NUM_DIGITS-1 are all zero. Digit 0 always shows. dp_mask still lights dp on a suppressed digit; the anode is enabled with seg off.
- Undefined: all digits display, including leading zeros. No extra logic is generated.

Test Plan:
- NUM_DIGITS=4, PRESCALE=4, GUARD_CYCLES=1, active-low. Release reset → an = 4'b1111 for 1 clk, then an = 4'b1110 with seg = 7'b0000001 for 4 clks, repeating per digit; frame_done pulses every 20 clks.
- load value = 16'hA18F → slots show seg 0111000 (F), 0000000 (8), 1001111 (1), 0001000 (A) on an[0..3], starting the frame after the load.
- load 16'h1234 at clock 3 of a frame, then 16'h5678 at clock 10 → the next frame shows 5678; 1234 is never displayed; mid-frame digits unchanged.
- blank_mask = 4'b0100, dp_mask = 4'b0001 → an[2] never asserted; dp = 0 only during the digit-0 slot.
- Assert rst_n low during digit 2 SHOW → outputs off asynchronously; after release the scan restarts at digit 0 and the shadow value is 0.
- With LEADING_ZERO_SUPPRESS_EN, value = 16'h0070 → digits 3 and 2 dark, digits 1 and 0 show "7" and "0"; value = 0 → only digit 0 lit.
